// File: rtl/mux2.sv
// rtl/mux2.sv - two-input WIDTH-bit mux with registered copy, valid flag and select-toggle counter
//
// Purpose:
//   Generic "d1 when sel=1, else d0" datapath selector. The combinational
//   result is always available on mux_out; a registered copy (mux_q) is
//   captured under en for timing closure. The registered side also counts
//   select transitions seen at clock edges and flags when mux_q is valid.
//
// Parameters:
//   WIDTH   data width of d1, d0, mux_out, mux_q
//   CNT_W   width of the select-toggle counter sel_cnt (wraps, no saturation)
//
// Ports:
//   clk      in   rising-edge clock for all registered outputs
//   rst_n    in   asynchronous active-low reset
//   d1       in   data routed out when sel=1
//   d0       in   data routed out when sel=0
//   sel      in   select: 1 picks d1, 0 picks d0
//   en       in   capture enable for mux_q
//   mux_out  out  combinational selected data (independent of clk/reset)
//   mux_q    out  registered selected data, 1-cycle latency
//   q_valid  out  high once mux_q holds a captured value
//   sel_cnt  out  number of sel transitions seen at clock edges
//   par_q    out  (only with MUX2_PARITY_EN) XOR-reduction of the value captured into mux_q
//
// Build option:
//   MUX2_PARITY_EN  adds the par_q output.

module mux2 #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d0,
  input  logic             sel,
  input  logic             en,
  output logic [WIDTH-1:0] mux_out,
  output logic [WIDTH-1:0] mux_q,
  output logic             q_valid,
`ifdef MUX2_PARITY_EN
  output logic             par_q,
`endif
  output logic [CNT_W-1:0] sel_cnt
);

  logic [WIDTH-1:0] data_q,     data_d;
  logic             valid_q,    valid_d;
  logic             sel_prev_q;
  logic [CNT_W-1:0] cnt_q,      cnt_d;

  // Combinational select path; the capture register reuses this same result
  // so that a sel change on a capture edge picks the new sel.
  assign mux_out = sel ? d1 : d0;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (en) begin
      data_d  = mux_out;
      valid_d = 1'b1;
    end
  end

  // sel_prev resets to 0, so a first edge with sel=1 counts as a transition.
  always_comb begin
    cnt_d = cnt_q;
    if (sel != sel_prev_q) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q     <= '0;
      valid_q    <= 1'b0;
      sel_prev_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      data_q     <= data_d;
      valid_q    <= valid_d;
      sel_prev_q <= sel;
      cnt_q      <= cnt_d;
    end
  end

  assign mux_q   = data_q;
  assign q_valid = valid_q;
  assign sel_cnt = cnt_q;

`ifdef MUX2_PARITY_EN
  logic parity_q, parity_d;

  always_comb begin
    parity_d = parity_q;
    if (en) begin
      parity_d = ^mux_out;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end

  assign par_q = parity_q;
`endif

endmodule

// File: tb/tb_mux2.sv
// tb/tb_mux2.sv - self-checking bench for mux2 (truth table, capture, counter wrap, async reset, parity)
`timescale 1ns/1ps

module tb_mux2;

  int tests = 0;
  int fails = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A: WIDTH=1, CNT_W=8 (truth table, reset test)
  logic       a_d1 = 1'b0, a_d0 = 1'b0, a_sel = 1'b0, a_en = 1'b0;
  logic       a_out, a_q, a_valid;
  logic [7:0] a_cnt;
  logic       a_rst_n = 1'b0;

  // Instance B: WIDTH=8, CNT_W=8 (registered capture, parity)
  logic [7:0] b_d1 = 8'h00, b_d0 = 8'h00;
  logic       b_sel = 1'b0, b_en = 1'b0;
  logic [7:0] b_out, b_q, b_cnt;
  logic       b_valid;

  // Instance C: WIDTH=8, CNT_W=2 (counter wrap)
  logic [7:0] c_d1 = 8'h00, c_d0 = 8'h00;
  logic       c_sel = 1'b0, c_en = 1'b0;
  logic [7:0] c_out, c_q;
  logic       c_valid;
  logic [1:0] c_cnt;

`ifdef MUX2_PARITY_EN
  logic a_par, b_par, c_par;
`endif

  mux2 #(.WIDTH(1), .CNT_W(8)) u_a (
    .clk(clk), .rst_n(a_rst_n), .d1(a_d1), .d0(a_d0), .sel(a_sel), .en(a_en),
    .mux_out(a_out), .mux_q(a_q), .q_valid(a_valid),
`ifdef MUX2_PARITY_EN
    .par_q(a_par),
`endif
    .sel_cnt(a_cnt)
  );

  mux2 #(.WIDTH(8), .CNT_W(8)) u_b (
    .clk(clk), .rst_n(rst_n), .d1(b_d1), .d0(b_d0), .sel(b_sel), .en(b_en),
    .mux_out(b_out), .mux_q(b_q), .q_valid(b_valid),
`ifdef MUX2_PARITY_EN
    .par_q(b_par),
`endif
    .sel_cnt(b_cnt)
  );

  mux2 #(.WIDTH(8), .CNT_W(2)) u_c (
    .clk(clk), .rst_n(rst_n), .d1(c_d1), .d0(c_d0), .sel(c_sel), .en(c_en),
    .mux_out(c_out), .mux_q(c_q), .q_valid(c_valid),
`ifdef MUX2_PARITY_EN
    .par_q(c_par),
`endif
    .sel_cnt(c_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic d1; logic d0; logic sel; logic exp;
  } tt_vec_t;

  typedef struct {
    logic [7:0] d1; logic [7:0] d0; logic sel; logic en;
    logic [7:0] exp_out; logic [7:0] exp_q; logic exp_valid; logic [7:0] exp_cnt; logic exp_par;
  } cap_vec_t;

  typedef struct {
    logic sel; logic [1:0] exp_cnt;
  } cnt_vec_t;

  tt_vec_t  tt  [8];
  cap_vec_t cap [6];
  cnt_vec_t cv  [7];

  initial begin
    // Truth table: d0 toggles every 25 ns, d1 every 50 ns, sel every 100 ns.
    tt[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
    tt[1] = '{1'b0, 1'b1, 1'b0, 1'b1};
    tt[2] = '{1'b1, 1'b0, 1'b0, 1'b0};
    tt[3] = '{1'b1, 1'b1, 1'b0, 1'b1};
    tt[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    tt[5] = '{1'b0, 1'b1, 1'b1, 1'b0};
    tt[6] = '{1'b1, 1'b0, 1'b1, 1'b1};
    tt[7] = '{1'b1, 1'b1, 1'b1, 1'b1};

    //            d1     d0     sel   en    out    q      vld   cnt    par
    cap[0] = '{8'hA5, 8'h3C, 1'b0, 1'b0, 8'h3C, 8'h00, 1'b0, 8'd0, 1'b0};
    cap[1] = '{8'hA5, 8'h3C, 1'b0, 1'b1, 8'h3C, 8'h3C, 1'b1, 8'd0, 1'b0};
    cap[2] = '{8'hA5, 8'h3C, 1'b1, 1'b1, 8'hA5, 8'hA5, 1'b1, 8'd1, 1'b0};
    cap[3] = '{8'hFF, 8'h3C, 1'b1, 1'b0, 8'hFF, 8'hA5, 1'b1, 8'd1, 1'b0};
    cap[4] = '{8'hFF, 8'h3C, 1'b0, 1'b0, 8'h3C, 8'hA5, 1'b1, 8'd2, 1'b0};
    cap[5] = '{8'h07, 8'h3C, 1'b1, 1'b1, 8'h07, 8'h07, 1'b1, 8'd3, 1'b1};

    cv[0] = '{1'b1, 2'd1};
    cv[1] = '{1'b0, 2'd2};
    cv[2] = '{1'b1, 2'd3};
    cv[3] = '{1'b0, 2'd0};
    cv[4] = '{1'b1, 2'd1};
    cv[5] = '{1'b1, 2'd1};
    cv[6] = '{1'b1, 2'd1};

    // Combinational truth table, applied while everything is held in reset.
    for (int i = 0; i < 8; i++) begin
      a_d1 = tt[i].d1; a_d0 = tt[i].d0; a_sel = tt[i].sel;
      #1;
      check($sformatf("truth_table[%0d]", i), {31'd0, a_out}, {31'd0, tt[i].exp});
      #24;
    end
    a_d1 = 1'b0; a_d0 = 1'b0; a_sel = 1'b0;

    // Reset state of the registered side.
    check("rst_b_mux_q", {24'd0, b_q}, 32'd0);
    check("rst_b_q_valid", {31'd0, b_valid}, 32'd0);
    check("rst_b_sel_cnt", {24'd0, b_cnt}, 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    a_rst_n = 1'b1;

    // Registered capture on WIDTH=8.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      b_d1 = cap[i].d1; b_d0 = cap[i].d0; b_sel = cap[i].sel; b_en = cap[i].en;
      #1;
      check($sformatf("cap_mux_out[%0d]", i), {24'd0, b_out}, {24'd0, cap[i].exp_out});
      @(posedge clk); #1;
      check($sformatf("cap_mux_q[%0d]", i), {24'd0, b_q}, {24'd0, cap[i].exp_q});
      check($sformatf("cap_q_valid[%0d]", i), {31'd0, b_valid}, {31'd0, cap[i].exp_valid});
      check($sformatf("cap_sel_cnt[%0d]", i), {24'd0, b_cnt}, {24'd0, cap[i].exp_cnt});
`ifdef MUX2_PARITY_EN
      check($sformatf("cap_par_q[%0d]", i), {31'd0, b_par}, {31'd0, cap[i].exp_par});
`endif
    end

    // Counter wrap on CNT_W=2; sel held constant at the end.
    check("cnt_start", {30'd0, c_cnt}, 32'd0);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      c_sel = cv[i].sel;
      @(posedge clk); #1;
      check($sformatf("cnt_seq[%0d]", i), {30'd0, c_cnt}, {30'd0, cv[i].exp_cnt});
    end
    check("cnt_q_valid_no_en", {31'd0, c_valid}, 32'd0);

    // Async reset mid-cycle on WIDTH=1: build mux_q=1, sel_cnt=5 first.
    @(negedge clk);
    a_d1 = 1'b1; a_d0 = 1'b1; a_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a_sel = (i % 2 == 0);
      @(posedge clk); #1;
    end
    check("pre_rst_mux_q", {31'd0, a_q}, 32'd1);
    check("pre_rst_sel_cnt", {24'd0, a_cnt}, 32'd5);
    #2;
    a_rst_n = 1'b0;
    #1;
    check("async_rst_mux_q", {31'd0, a_q}, 32'd0);
    check("async_rst_q_valid", {31'd0, a_valid}, 32'd0);
    check("async_rst_sel_cnt", {24'd0, a_cnt}, 32'd0);
    a_sel = 1'b0; a_d0 = 1'b0; a_d1 = 1'b1;
    #1;
    check("rst_mux_out_d0", {31'd0, a_out}, 32'd0);
    a_sel = 1'b1;
    #1;
    check("rst_mux_out_d1", {31'd0, a_out}, 32'd1);
    // Registered outputs stay cleared across a clock edge while held in reset.
    @(posedge clk); #1;
    check("rst_hold_mux_q", {31'd0, a_q}, 32'd0);
    check("rst_hold_sel_cnt", {24'd0, a_cnt}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
